mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  E-stage multiply/divide unit owning the HI/LO registers of the P6 pipeline.
//  It is the producer side of the md-hazard handshake: it launches mult/multu/div/divu,
//  holds busy for a fixed latency, then commits HI/LO.
//  It also services mfhi/mflo/mthi/mtlo. The hazard unit stalls D-stage md instructions
//  while (start | busy), where start is decoded from md_op in E.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
//  CNT_W        4   counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high
//  md_op      in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo; 9-15 = none
//  a          in   32  rs operand (forwarded ALU-a value)
//  b          in   32  rt operand (forwarded ALU-b value)
//  start      out  1   comb: md_op in {1..4} and not busy; feeds hazard unit
//  busy       out  1   registered: operation in flight
//  hi         out  32  architectural HI
//  lo         out  32  architectural LO
//  md_rdata   out  32  comb: hi if md_op==mfhi, lo if md_op==mflo, else 0
// BEHAVIOUR
//  - Reset: busy=0, cnt=0, hi=0, lo=0, pending result regs=0. Applies at any time;
//    an in-flight op is aborted with no commit.
//  - Launch: at the edge ending cycle T with start=1, a/b are sampled and the
//    64-bit result is computed into pend_hi/pend_lo. cnt loads N
//    (MULT_CYCLES or DIV_CYCLES) and busy=1 from cycle T+1.
//  - Count: while busy, cnt decrements each edge. At the edge where cnt==1:
//    hi<=pend_hi, lo<=pend_lo, busy<=0, cnt<=0.
//    busy is therefore high for exactly N cycles (T+1..T+N).
//    New hi/lo are visible in cycle T+N+1, the same cycle busy is first low.
//  - Arithmetic:
//    - mult: {hi,lo}=$signed(a)*$signed(b). multu: unsigned 64-bit product.
//    - div: lo=signed quotient truncated toward zero, hi=remainder with the sign of a.
//    - divu: unsigned quotient/remainder.
//    - 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0.
//    - Divide by zero (div/divu): the op runs its full latency but commits nothing;
//      hi/lo are unchanged.
//  - mthi/mtlo: write hi<=a / lo<=a at the edge ending the cycle they are presented,
//    only when busy=0. They are ignored while busy; the hazard unit guarantees this
//    does not occur.
//  - mfhi/mflo: md_rdata is combinational from the current hi/lo.
//    - During busy: returns the pre-op value.
//    - In the commit-edge cycle: returns the old value.
//  - md_op in {1..4} while busy: start=0, ignored. Not a legal pipeline state,
//    since the hazard unit stalls it.
//  - Back-to-back: a new launch is accepted in cycle T+N+1 (first cycle busy=0)
//    and sees the committed hi/lo.
//  - No outputs are X after reset; unused encodings behave as none.
// TESTING
//  1. mult a=0xFFFFFFFE(-2), b=3 at T -> busy=1 for T+1..T+5;
//     T+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
//  3. div a=-7(0xFFFFFFF9), b=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//     divu same operands -> lo=0x7FFFFFFC, hi=1.
//  4. mthi a=0x12345678, then mflo/mfhi -> md_rdata=0x12345678 next cycle for mfhi.
//     Then div by b=0 -> busy 10 cycles, hi/lo unchanged.
//  5. reset=1 asserted at the 3rd busy cycle of a mult -> next cycle busy=0, hi=lo=0,
//     no later commit.
//  6. mult at T, mfhi at T+5 -> old hi. mult launched at T+6 -> accepted, start=1,
//     busy T+7..T+11.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: E-stage multiply/divide unit that owns the HI/LO registers.
//   Launches mult/multu/div/divu and holds busy for a fixed latency. At the
//   end of that latency it commits the 64-bit result to HI/LO. It also
//   services mfhi/mflo (combinational read) and mthi/mtlo (write when idle).
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset; aborts an in-flight op
//   md_op     0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//   a, b      rs / rt operands
//   start     comb: arithmetic op presented while idle (to hazard unit)
//   busy      registered: operation in flight
//   hi, lo    architectural HI/LO
//   md_rdata  comb: hi for mfhi, lo for mflo, else 0
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       hi_reg, hi_next;
  logic [31:0]       lo_reg, lo_next;
  logic [31:0]       pend_hi_reg, pend_hi_next;
  logic [31:0]       pend_lo_reg, pend_lo_next;
  logic              pend_ok_reg, pend_ok_next;  // result may be committed

  logic              is_arith;
  logic              is_mul;
  logic              div_zero;
  logic              div_ovf;
  logic [31:0]       b_divs;
  logic [31:0]       b_divu;
  logic signed [63:0] prod_s;
  logic [63:0]       prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]       quo_u;
  logic [31:0]       rem_u;

  assign is_arith = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign is_mul   = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign busy     = (state_reg == ST_BUSY);
  assign start    = is_arith && !busy;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  assign md_rdata = (md_op == OP_MFHI) ? hi_reg :
                    (md_op == OP_MFLO) ? lo_reg : 32'd0;

  // Divisors are substituted with 1 where the raw division is undefined.
  // For INT_MIN / -1 dividing by 1 yields exactly the required quotient
  // 0x80000000 with remainder 0. A zero divisor is never committed anyway.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_divs   = (div_zero || div_ovf) ? 32'd1 : b;
  assign b_divu   = div_zero ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign quo_s  = $signed(a) / $signed(b_divs);
  assign rem_s  = $signed(a) % $signed(b_divs);
  assign quo_u  = a / b_divu;
  assign rem_u  = a % b_divu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_ok_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_ok_reg <= pend_ok_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_ok_next = pend_ok_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_BUSY;
          cnt_next     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          pend_ok_next = is_mul || !div_zero;
          case (md_op)
            OP_MULT: begin
              pend_hi_next = prod_s[63:32];
              pend_lo_next = prod_s[31:0];
            end
            OP_MULTU: begin
              pend_hi_next = prod_u[63:32];
              pend_lo_next = prod_u[31:0];
            end
            OP_DIV: begin
              pend_hi_next = rem_s;
              pend_lo_next = quo_s;
            end
            default: begin
              pend_hi_next = rem_u;
              pend_lo_next = quo_u;
            end
          endcase
        end else if (md_op == OP_MTHI) begin
          hi_next = a;
        end else if (md_op == OP_MTLO) begin
          lo_next = a;
        end
      end
      default: begin
        // Launches and moves are ignored here; the hazard unit stalls them.
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          if (pend_ok_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
    endcase
  end

endmodule
